// File: rtl/axil_rr_master_arbiter.sv
// ---------------------------------------------------------------------------
// axil_rr_master_arbiter
//
// Shares one AXI4-Lite slave register port between two fabric requesters.
// Requesters issue single-word read/write commands over a valid/ready port;
// the block grants round-robin, runs exactly one AXI4-Lite transaction at a
// time and returns a one-cycle response strobe to the granted requester.
// Commands outside [0, ADDR_LIMIT) or not word aligned are answered locally
// with SLVERR and never reach the bus.
//
// Ports
//   ACLK, ARESET          clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester command handshake (bit i = req i)
//   req_write/addr/wdata  per-requester command fields (slice i = req i)
//   rsp_valid             per-requester one-cycle response strobe
//   rsp_rdata/rsp_resp    shared response payload, qualified by rsp_valid
//   M_AXI_*               AXI4-Lite master (AW, W, B, AR, R channels)
// ---------------------------------------------------------------------------
module axil_rr_master_arbiter #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  ADDR_LIMIT = 'h10
) (
    input  logic                      ACLK,
    input  logic                      ARESET,

    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0]                req_write,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
    output logic [1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,

    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WB, S_RA, S_RD, S_RSP
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_q, last_d;     // requester granted most recently
    logic                    gnt_q, gnt_d;       // requester owning the current transaction
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;

    logic                    gsel;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    aw_hs, w_hs;

    // Winner: the requester that did not win last time when both ask,
    // otherwise whichever one is asking.
    always_comb begin
        gsel      = (req_valid == 2'b11) ? ~last_q : req_valid[1];
        sel_write = gsel ? req_write[1] : req_write[0];
        sel_addr  = gsel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        sel_wdata = gsel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
    end

    assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID  & M_AXI_WREADY;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    gnt_d     = gsel;
                    last_d    = gsel;
                    wr_d      = sel_write;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    rdata_d   = '0;
                    resp_d    = 2'b00;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (sel_addr >= ADDR_LIMIT || sel_addr[1:0] != 2'b00) begin
                        resp_d  = 2'b10;           // rejected locally, no bus traffic
                        state_d = S_RSP;
                    end else begin
                        state_d = sel_write ? S_WR : S_RA;
                    end
                end
            end
            S_WR: begin
                // AW and W complete independently; leave once both are done.
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q  | w_hs;
                if (aw_done_d && w_done_d)
                    state_d = S_WB;
            end
            S_WB: begin
                if (M_AXI_BVALID) begin
                    resp_d  = M_AXI_BRESP;
                    state_d = S_RSP;
                end
            end
            S_RA: begin
                if (M_AXI_ARREADY)
                    state_d = S_RD;
            end
            S_RD: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                    state_d = S_RSP;
                end
            end
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // req_ready is combinational on req_valid, so it is gated by reset to
    // keep it low while ARESET is held.
    assign req_ready = (state_q == S_IDLE && |req_valid && !ARESET)
                       ? (gsel ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid = (state_q == S_RSP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = (state_q == S_WR) && !aw_done_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = (state_q == S_WR) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == S_WB);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (state_q == S_RA);
    assign M_AXI_RREADY  = (state_q == S_RD);

endmodule
